// File: rtl/trap_csr_unit.sv
// Machine-mode trap and CSR unit: commits exception state, handles mret,
// serves CSR accesses from execute and keeps the mcycle/minstret counters.
module trap_csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_exception_i,
  input  logic [31:0] exception_program_counter_i,
  input  logic [31:0] exception_adress_i,
  input  logic [2:0]  exception_cause_i,
  input  logic        mret_i,
  input  logic        instr_retired_i,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  output logic        redirect_en_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RETURN} state_t;

  state_t      r_state;
  logic        r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0] r_mcycle, r_minstret;
  logic        r_redirect_en;
  logic [31:0] r_redirect_pc;

  logic        w_legal, w_we;
  logic [31:0] w_rdata, w_wval, w_cause, w_tval;

  always_comb begin
    w_legal = 1'b1;
    w_rdata = '0;
    case (csr_addr_i)
      12'h300: w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'hB00: w_rdata = r_mcycle[31:0];
      12'hB80: w_rdata = r_mcycle[63:32];
      12'hB02: w_rdata = r_minstret[31:0];
      12'hB82: w_rdata = r_minstret[63:32];
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      2'b01:   w_wval = csr_wdata_i;
      2'b10:   w_wval = w_rdata | csr_wdata_i;
      2'b11:   w_wval = w_rdata & ~csr_wdata_i;
      default: w_wval = w_rdata;
    endcase
  end

  always_comb begin
    w_cause = 32'd2;
    w_tval  = '0;
    case (exception_cause_i)
      3'd0: begin w_cause = 32'd0; w_tval = exception_program_counter_i; end
      3'd2: begin w_cause = 32'd3; w_tval = exception_program_counter_i; end
      3'd3: begin w_cause = 32'd4; w_tval = exception_adress_i; end
      3'd4: begin w_cause = 32'd6; w_tval = exception_adress_i; end
      3'd5: w_cause = 32'd11;
      default: ;
    endcase
  end

  // Writes only land from IDLE and lose to a same-cycle exception.
  assign w_we = csr_en_i && (csr_op_i != 2'b00) && w_legal &&
                (r_state == S_IDLE) && !en_exception_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mtvec       <= {MTVEC_RESET[31:2], 2'b00};
      r_mscratch    <= '0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_mcycle      <= '0;
      r_minstret    <= '0;
      r_redirect_en <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      if (COUNTERS_EN) begin
        // A half-write replaces the increment and leaves the other half untouched.
        if (w_we && csr_addr_i == 12'hB00)      r_mcycle <= {r_mcycle[63:32], w_wval};
        else if (w_we && csr_addr_i == 12'hB80) r_mcycle <= {w_wval, r_mcycle[31:0]};
        else                                    r_mcycle <= r_mcycle + 64'd1;
        if (w_we && csr_addr_i == 12'hB02)      r_minstret <= {r_minstret[63:32], w_wval};
        else if (w_we && csr_addr_i == 12'hB82) r_minstret <= {w_wval, r_minstret[31:0]};
        else if (instr_retired_i)               r_minstret <= r_minstret + 64'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (en_exception_i) begin
            r_mepc        <= {exception_program_counter_i[31:1], 1'b0};
            r_mcause      <= w_cause;
            r_mtval       <= w_tval;
            r_mpie        <= r_mie;
            r_mie         <= 1'b0;
            r_redirect_en <= 1'b1;
            r_redirect_pc <= {r_mtvec[31:2], 2'b00};
            r_state       <= S_TRAP;
          end else begin
            if (w_we) begin
              case (csr_addr_i)
                12'h300: begin r_mie <= w_wval[3]; r_mpie <= w_wval[7]; end
                12'h305: r_mtvec    <= {w_wval[31:2], 2'b00};
                12'h340: r_mscratch <= w_wval;
                12'h341: r_mepc     <= {w_wval[31:1], 1'b0};
                12'h342: r_mcause   <= w_wval;
                12'h343: r_mtval    <= w_wval;
                default: ;
              endcase
            end
            if (mret_i) begin
              r_mie         <= r_mpie;
              r_mpie        <= 1'b1;
              r_redirect_en <= 1'b1;
              r_redirect_pc <= r_mepc;
              r_state       <= S_RETURN;
            end
          end
        end
        default: begin
          r_redirect_en <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = csr_en_i && !w_legal;
  assign redirect_en_o = r_redirect_en;
  assign redirect_pc_o = r_redirect_pc;
  assign trap_busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_csr_unit.sv
// Randomized bench for trap_csr_unit against a behavioural model of the
// trap/CSR rules, preceded by a short directed scenario.
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_exception_i = 1'b0;
  logic [31:0] exception_program_counter_i = '0;
  logic [31:0] exception_adress_i = '0;
  logic [2:0]  exception_cause_i = '0;
  logic        mret_i = 1'b0;
  logic        instr_retired_i = 1'b0;
  logic        csr_en_i = 1'b0;
  logic [1:0]  csr_op_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        redirect_en_o;
  logic [31:0] redirect_pc_o;
  logic        trap_busy_o;

  always #5 clk = ~clk;

  trap_csr_unit #(.MTVEC_RESET(32'h0000_0100), .COUNTERS_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .en_exception_i(en_exception_i),
    .exception_program_counter_i(exception_program_counter_i),
    .exception_adress_i(exception_adress_i),
    .exception_cause_i(exception_cause_i),
    .mret_i(mret_i), .instr_retired_i(instr_retired_i),
    .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .redirect_en_o(redirect_en_o),
    .redirect_pc_o(redirect_pc_o), .trap_busy_o(trap_busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit          m_mie, m_mpie, m_busy, m_red_en;
  logic [31:0] m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval, m_red_pc;
  logic [63:0] m_cyc, m_ret;
  int unsigned cause_tab[8] = '{0, 2, 3, 4, 6, 11, 2, 2};
  logic [31:0] last_rdata;
  logic        last_illegal;

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_busy = 0; m_red_en = 0; m_red_pc = 0;
    m_mtvec = 32'h100; m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cyc = 0; m_ret = 0;
  endfunction

  function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
    v = 0;
    m_read = 1;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
      12'h305: v = m_mtvec;
      12'h340: v = m_scratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ret[31:0];
      12'hB82: v = m_ret[63:32];
      default: m_read = 0;
    endcase
  endfunction

  function automatic void m_update();
    logic [31:0] old, nv, target, pc;
    logic [63:0] cyc_n, ret_n;
    bit legal;
    cyc_n = m_cyc + 1;
    ret_n = instr_retired_i ? m_ret + 1 : m_ret;
    pc = exception_program_counter_i;
    if (m_busy) begin
      m_busy = 0;
      m_red_en = 0;
    end else if (en_exception_i) begin
      m_mepc = pc & 32'hFFFF_FFFE;
      m_mcause = cause_tab[exception_cause_i];
      case (exception_cause_i)
        3'd0, 3'd2: m_mtval = pc;
        3'd3, 3'd4: m_mtval = exception_adress_i;
        default:    m_mtval = 0;
      endcase
      m_mpie = m_mie; m_mie = 0;
      m_busy = 1; m_red_en = 1; m_red_pc = m_mtvec & 32'hFFFF_FFFC;
    end else begin
      target = m_mepc;
      legal = m_read(csr_addr_i, old);
      nv = (csr_op_i == 2'b01) ? csr_wdata_i :
           (csr_op_i == 2'b10) ? (old | csr_wdata_i) : (old & ~csr_wdata_i);
      if (csr_en_i && csr_op_i != 2'b00 && legal) begin
        case (csr_addr_i)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
          12'h340: m_scratch = nv;
          12'h341: m_mepc = nv & 32'hFFFF_FFFE;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          12'hB00: cyc_n = {m_cyc[63:32], nv};
          12'hB80: cyc_n = {nv, m_cyc[31:0]};
          12'hB02: ret_n = {m_ret[63:32], nv};
          12'hB82: ret_n = {nv, m_ret[31:0]};
          default: ;
        endcase
      end
      if (mret_i) begin
        m_mie = m_mpie; m_mpie = 1;
        m_busy = 1; m_red_en = 1; m_red_pc = target;
      end
    end
    m_cyc = cyc_n;
    m_ret = ret_n;
  endfunction

  task automatic step(input bit e, input logic [31:0] pc, input logic [31:0] ad,
                      input logic [2:0] c, input bit mr, input bit rt, input bit ce,
                      input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] v;
    bit lg;
    en_exception_i = e; exception_program_counter_i = pc; exception_adress_i = ad;
    exception_cause_i = c; mret_i = mr; instr_retired_i = rt;
    csr_en_i = ce; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
    #1;
    lg = m_read(a, v);
    check("rdata", csr_rdata_o, v);
    check("illegal", csr_illegal_o, ce && !lg);
    last_rdata = csr_rdata_o;
    last_illegal = csr_illegal_o;
    @(posedge clk); #1;
    m_update();
    check("redirect_en", redirect_en_o, m_red_en);
    check("redirect_pc", redirect_pc_o, m_red_pc);
    check("trap_busy", trap_busy_o, m_busy);
  endtask

  task automatic rd(input logic [11:0] a);
    step(0, 0, 0, 0, 0, 0, 1, 2'b00, a, 0);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 0, 1, op, a, d);
  endtask

  task automatic do_reset();
    rst_i = 1;
    en_exception_i = 0; mret_i = 0; csr_en_i = 0; instr_retired_i = 0;
    #1;
    check("rst_redirect_en", redirect_en_o, 0);
    check("rst_busy", trap_busy_o, 0);
    @(posedge clk); #1;
    m_reset();
    rst_i = 0;
  endtask

  logic [11:0] addr_pool[16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'h7C0, 12'h301, 12'hB01, 12'h000, 12'h344, 12'hF14};

  initial begin
    #2;
    do_reset();

    rd(12'h300); check("reset_mstatus", last_rdata, 32'h1800);
    rd(12'h305); check("reset_mtvec", last_rdata, 32'h100);
    check("reset_no_redirect", redirect_en_o, 0);

    wr(2'b10, 12'h300, 32'h8);
    step(1, 32'h80, 32'h1003, 3'd3, 0, 0, 0, 2'b00, 12'h0, 0);
    check("trap_redirect_en", redirect_en_o, 1);
    check("trap_redirect_pc", redirect_pc_o, 32'h100);
    step(1, 32'h444, 32'h0, 3'd1, 0, 0, 1, 2'b00, 12'h341, 0);
    check("trap_mepc", last_rdata, 32'h80);
    check("trap_pulse_width", redirect_en_o, 0);
    rd(12'h342); check("trap_mcause", last_rdata, 32'd4);
    rd(12'h343); check("trap_mtval", last_rdata, 32'h1003);
    rd(12'h300); check("trap_mstatus", last_rdata, 32'h1880);

    step(0, 0, 0, 0, 1, 0, 0, 2'b00, 12'h0, 0);
    check("mret_redirect_en", redirect_en_o, 1);
    check("mret_redirect_pc", redirect_pc_o, 32'h80);
    rd(12'h300); check("mret_mstatus", last_rdata, 32'h1888);

    step(1, 32'h200, 0, 3'd5, 1, 0, 0, 2'b00, 12'h0, 0);
    check("exc_beats_mret_pc", redirect_pc_o, 32'h100);
    step(1, 32'h999, 32'h5, 3'd0, 0, 0, 1, 2'b00, 12'h342, 0);
    check("ecall_mcause", last_rdata, 32'd11);
    check("exc_in_trap_ignored", redirect_en_o, 0);
    rd(12'h343); check("ecall_mtval", last_rdata, 32'h0);
    rd(12'h341); check("ecall_mepc", last_rdata, 32'h200);

    wr(2'b01, 12'hB80, 32'h0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80); check("mcycleh_before_carry", last_rdata, 32'h0);
    rd(12'hB80); check("mcycleh_carry", last_rdata, 32'h1);
    rd(12'h7C0);
    check("illegal_flag", last_illegal, 1);
    check("illegal_rdata", last_rdata, 32'h0);

    wr(2'b01, 12'h340, 32'hDEAD_BEEF);
    step(1, 32'h300, 0, 3'd1, 0, 0, 0, 2'b00, 12'h0, 0);
    do_reset();
    rd(12'h300); check("rst_trap_mstatus", last_rdata, 32'h1800);
    rd(12'h340); check("rst_trap_mscratch", last_rdata, 32'h0);
    rd(12'h341); check("rst_trap_mepc", last_rdata, 32'h0);
    check("rst_trap_no_redirect", redirect_en_o, 0);

    for (int i = 0; i < 3000; i++) begin
      bit e, mr, rt, ce;
      logic [1:0] op;
      logic [11:0] a;
      logic [31:0] wd;
      e  = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 7) == 0);
      rt = $urandom_range(0, 1);
      ce = $urandom_range(0, 1);
      op = 2'($urandom_range(0, 3));
      a  = addr_pool[$urandom_range(0, 15)];
      wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if (mr && a == 12'h300) op = 2'b00;
      step(e, $urandom, $urandom, 3'($urandom_range(0, 7)), mr, rt, ce, op, a, wd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap and CSR unit.
- Consumes the prioritised exception report from the pipeline controller: enable, PC, faulting address and 3-bit cause.
- Commits mepc/mcause/mtval/mstatus on an exception and redirects fetch to mtvec. Executes mret and serves CSR instructions issued from the execute stage.
- Keeps the mcycle and minstret counters.

Parameters:
MTVEC_RESET, 32'h0000_0100, reset value of mtvec
COUNTERS_EN, 1, 1 = mcycle/minstret implemented; 0 = those addresses read 0 and are writable no-ops

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
en_exception_i  in  1  exception report valid (from pipeline controller)
exception_program_counter_i  in  32  PC of faulting instruction
exception_adress_i  in  32  faulting data address (load/store misaligned)
exception_cause_i  in  3  internal cause code
mret_i  in  1  mret reached execute, single-cycle pulse
instr_retired_i  in  1  one instruction retired this cycle
csr_en_i  in  1  CSR instruction in execute
csr_op_i  in  2  01 write, 10 set, 11 clear, 00 read-only
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  rs1/zimm operand
csr_rdata_o  out  32  old CSR value (combinational)
csr_illegal_o  out  1  csr_en_i to an unimplemented address (combinational)
redirect_en_o  out  1  fetch redirect pulse
redirect_pc_o  out  32  redirect target
trap_busy_o  out  1  high in TRAP/RETURN states

Behaviour:
- Reset values: redirect_en_o 0, redirect_pc_o 0, trap_busy_o 0, state IDLE.
- Register reset values: mstatus 32'h0000_1800 (MPP=11, MIE=0, MPIE=0), mtvec MTVEC_RESET; mscratch, mepc, mcause, mtval, mcycle, minstret all 0.
- Reset asserted mid-trap returns to IDLE immediately; no redirect is issued.
- Cause map, internal code -> mcause:
  - 0 instr misaligned -> 0, mtval = PC
  - 1 illegal -> 2, mtval = 0
  - 2 breakpoint -> 3, mtval = PC
  - 3 load misaligned -> 4, mtval = address
  - 4 store misaligned -> 6, mtval = address
  - 5 env call -> 11, mtval = 0
  - 6–7 reserved: treated as illegal
- FSM states: IDLE, TRAP, RETURN.
- IDLE & en_exception_i (cycle N):
  - At edge N: mepc <= {pc[31:1],0}; mcause and mtval per map; MPIE <= MIE; MIE <= 0; -> TRAP.
  - Cycle N+1: redirect_en_o=1, redirect_pc_o={mtvec[31:2],2'b00}; next edge -> IDLE.
- IDLE & mret_i & !en_exception_i:
  - At edge: MIE <= MPIE; MPIE <= 1; target latched = mepc before any same-cycle write; -> RETURN.
  - Next cycle: redirect_en_o=1 with the latched target; then -> IDLE.
- In TRAP/RETURN: en_exception_i, mret_i and CSR writes are ignored. The pipeline is being flushed, so csr_rdata_o stays valid but no write occurs.
- Simultaneous exception + mret: exception wins, mret dropped.
- Simultaneous exception + CSR write: write suppressed.
- redirect_en_o is exactly one cycle wide; back-to-back traps are at least 2 cycles apart.
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; MPP reads 11.
  - mtvec 0x305: bits[1:0] read 0.
  - mscratch 0x340: fully writable.
  - mepc 0x341: bit0 reads 0.
  - mcause 0x342, mtval 0x343: writable.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: 64-bit counters.
  - Any other address: csr_illegal_o=1, rdata 0, no write.
- Write value: op 01 wdata; 10 old|wdata; 11 old&~wdata; op 00 never writes. Writes land at the clock edge.
- Counters:
  - mcycle +1 every cycle.
  - minstret +1 when instr_retired_i.
  - 64-bit wrap from all-ones to 0.
  - A CSR write to either half takes precedence over the increment that cycle; the other half is unchanged that cycle (no carry).

Test Plan:
- Reset, then read 0x300 / 0x305 -> 32'h0000_1800 / 32'h0000_0100; redirect_en_o=0.
- Set MIE (op 10, 0x300, wdata 8); then exception cause 3, PC 32'h80, addr 32'h1003 -> mepc 32'h80, mcause 4, mtval 32'h1003, mstatus 32'h1880; next cycle one redirect pulse to 32'h100.
- Then mret -> next cycle redirect to 32'h80; mstatus 32'h1888.
- Exception cause 5 and mret same cycle -> only trap taken (mcause 11, mtval 0); an exception asserted during TRAP is ignored.
- Write mcycle 32'hFFFF_FFFF with mcycleh 0, let it run -> mcycleh reads 1 two cycles after the write; read of 0x7C0 -> csr_illegal_o=1, rdata 0.
- Assert rst_i in TRAP state -> no redirect pulse, all registers at reset values.
